mem_port_arbiter: RTL

- Shares one single-ported unified memory between the instruction-fetch requester and the data (load/store) requester of the in-order pipeline.
- Serialises the two accesses and holds the returned read data.
- Drives `busy` to the hazard logic, so the pipeline stalls (F/D/E/M held) until every access required by the current pipeline cycle has completed.
- Data accesses take priority over fetch, because the data access belongs to the older instruction.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins over fetch; busy stalls the pipeline until every needed access has completed.
module mem_port_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_valid,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_valid,
  output logic            mem_req,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int unsigned BW = DW / 8;

  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

  state_t          state_q, state_d;
  logic            i_done, i_done_d;
  logic            d_done, d_done_d;
  logic            mem_req_d, mem_we_d;
  logic [BW-1:0]   mem_be_d;
  logic [AW-1:0]   mem_addr_d;
  logic [DW-1:0]   mem_wdata_d;
  logic [DW-1:0]   if_rdata_d, d_rdata_d;

  assign busy     = (if_req && !i_done) || (d_req && !d_done);
  assign if_valid = i_done;
  assign d_valid  = d_done;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_be    <= mem_be_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      i_done    <= i_done_d;
      d_done    <= d_done_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

  // Next-state: launch from IDLE, hold mem_* until mem_ready, then record completion
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    i_done_d    = i_done;
    d_done_d    = d_done;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;

    // Pipeline advances on this edge: results are consumed
    if (!busy) begin
      i_done_d = 1'b0;
      d_done_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (d_req && !d_done) begin
          mem_addr_d  = d_addr;
          mem_we_d    = d_we;
          mem_be_d    = d_we ? d_be : {BW{1'b1}};
          mem_wdata_d = d_wdata;
          mem_req_d   = 1'b1;
          state_d     = D_ACC;
        end else if (if_req && !i_done) begin
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
          mem_be_d   = {BW{1'b1}};
          mem_req_d  = 1'b1;
          state_d    = I_ACC;
        end
      end
      D_ACC: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          if (!mem_we) d_rdata_d = mem_rdata;
          state_d   = IDLE;
        end
      end
      I_ACC: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          i_done_d   = 1'b1;
          if_rdata_d = mem_rdata;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
